// File: rtl/zoran_nios_recv_port.sv
// zoran_nios_recv_port: Avalon-MM input port.
// Synchronises an asynchronous input bus and detects edges of a selectable
// type. It keeps per-bit sticky capture flags and a maskable level interrupt.
// On every unmasked edge it snapshots the input word into a FIFO.
//
// Bus handshake: a read is chipselect & ~read_n. The data for that read
// appears on readdata after the same clk edge (latency 1) and is held until
// the next read. A write is chipselect & ~write_n and takes effect at that
// edge. There are no wait states; every access completes in one cycle.
module zoran_nios_recv_port #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_edge_cap;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge;
  logic             w_rd_en;
  logic             w_wr_en;
  logic [WIDTH-1:0] w_ec_clr;
  logic [WIDTH-1:0] w_ec_next;
  logic [WIDTH-1:0] w_mask_next;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_fifo_wr;
  logic             w_drop;
  logic             w_ovf_next;
  logic [31:0]      w_sync32;
  logic [31:0]      w_head32;
  logic [31:0]      w_mask32;
  logic [31:0]      w_ec32;
  logic [31:0]      w_status;
  logic [31:0]      w_rd_mux;

  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign w_rise  = w_sync & ~r_prev;
  assign w_fall  = ~w_sync & r_prev;
  assign w_rd_en = chipselect & ~read_n;
  assign w_wr_en = chipselect & ~write_n;

  // Select which transitions count as an edge.
  always_comb begin
    w_edge = w_rise;
    if (EDGE_TYPE == 1)      w_edge = w_fall;
    else if (EDGE_TYPE == 2) w_edge = w_rise | w_fall;
  end

  // Write-1-to-clear of the capture flags; a new edge wins over the clear.
  always_comb begin
    w_ec_clr    = '0;
    w_mask_next = r_irq_mask;
    if (w_wr_en && address == 3'd3) w_ec_clr    = writedata[WIDTH-1:0];
    if (w_wr_en && address == 3'd2) w_mask_next = writedata[WIDTH-1:0];
    w_ec_next = (r_edge_cap & ~w_ec_clr) | w_edge;
  end

  // FIFO control: a pop frees the slot a same-cycle push needs when full.
  always_comb begin
    w_empty    = (r_count == '0);
    w_full     = (r_count == FULL_COUNT);
    w_push     = |(w_edge & r_irq_mask);
    w_pop      = w_rd_en && (address == 3'd1) && !w_empty;
    w_fifo_wr  = w_push && (!w_full || w_pop);
    w_drop     = w_push && w_full && !w_pop;
    w_ovf_next = w_drop ||
                 (r_overflow && !(w_wr_en && address == 3'd4 && writedata[2]));
  end

  // Zero-extend the narrow registers onto the 32-bit read bus.
  always_comb begin
    w_sync32 = '0;
    w_head32 = '0;
    w_mask32 = '0;
    w_ec32   = '0;
    w_status = '0;
    w_sync32[WIDTH-1:0] = w_sync;
    if (!w_empty) w_head32[WIDTH-1:0] = r_mem[r_rd_ptr];
    w_mask32[WIDTH-1:0] = r_irq_mask;
    w_ec32[WIDTH-1:0]   = r_edge_cap;
    w_status[8 +: CW]   = r_count;
    w_status[2]         = r_overflow;
    w_status[1]         = w_full;
    w_status[0]         = w_empty;
  end

  // Register-map read mux.
  always_comb begin
    w_rd_mux = '0;
    case (address)
      3'd0:    w_rd_mux = w_sync32;
      3'd1:    w_rd_mux = w_head32;
      3'd2:    w_rd_mux = w_mask32;
      3'd3:    w_rd_mux = w_ec32;
      3'd4:    w_rd_mux = w_status;
      default: w_rd_mux = '0;
    endcase
  end

  // Synchroniser chain and previous-value register for edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
      r_prev <= w_sync;
    end
  end

  // Capture flags, interrupt mask, overflow flag and the registered irq.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_edge_cap <= '0;
      r_irq_mask <= '0;
      r_overflow <= 1'b0;
      irq        <= 1'b0;
    end else begin
      r_edge_cap <= w_ec_next;
      r_irq_mask <= w_mask_next;
      r_overflow <= w_ovf_next;
      irq        <= |(w_ec_next & w_mask_next);
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_fifo_wr && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_fifo_wr && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // FIFO storage; contents are only meaningful behind the count.
  always_ff @(posedge clk) begin
    if (w_fifo_wr) r_mem[r_wr_ptr] <= w_sync;
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk) begin
    if (!reset_n)     readdata <= '0;
    else if (w_rd_en) readdata <= w_rd_mux;
  end

endmodule

// File: tb/tb_zoran_nios_recv_port.sv
// Bench for zoran_nios_recv_port: directed steps plus a random phase. Every
// cycle is checked against a queue-based reference model of the port.
module tb_zoran_nios_recv_port;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_cs = 1'b0;
  logic        bus_sel = 1'b0;
  logic        bus_rd = 1'b0;
  logic        bus_wr = 1'b0;
  logic [2:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] in0 = '0;
  logic [7:0]  in1 = '0;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;
  logic        cs0, cs1;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state
  logic [31:0] m_fifo[$];
  logic [31:0] hist[$];
  logic [31:0] m_ec, m_mask, m_rd;
  logic        m_ovf, m_irq;

  // scoreboard of expected FIFO pops
  logic [31:0] exp_q[$];

  assign cs0 = bus_cs & ~bus_sel;
  assign cs1 = bus_cs & bus_sel;

  // clock / reset
  always #5 clk = ~clk;

  zoran_nios_recv_port #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0), .FIFO_DEPTH(D)) dut0 (
    .clk(clk), .reset_n(rst_n), .address(bus_addr), .chipselect(cs0),
    .read_n(~bus_rd), .write_n(~bus_wr), .writedata(bus_wdata),
    .in_port(in0), .readdata(rd0), .irq(irq0));

  zoran_nios_recv_port #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset_n(rst_n), .address(bus_addr), .chipselect(cs1),
    .read_n(~bus_rd), .write_n(~bus_wr), .writedata(bus_wdata),
    .in_port(in1), .readdata(rd1), .irq(irq1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_of();
    logic [31:0] st;
    st = '0;
    st[15:8] = 8'(m_fifo.size());
    st[2] = m_ovf;
    st[1] = (m_fifo.size() == D);
    st[0] = (m_fifo.size() == 0);
    return st;
  endfunction

  // One clock edge of the model for dut0 (rising-edge capture).
  task automatic model_edge();
    logic [31:0] s, p, ev, clr, ec_n, mask_n;
    bit rd, wr, push, pop, drop;
    if (!rst_n) begin
      m_fifo.delete();
      hist = '{32'h0, 32'h0, 32'h0};
      m_ec = '0; m_mask = '0; m_rd = '0; m_ovf = 1'b0; m_irq = 1'b0;
      return;
    end
    s  = hist[1];
    p  = hist[0];
    ev = s & ~p;
    rd = bus_cs && !bus_sel && bus_rd;
    wr = bus_cs && !bus_sel && bus_wr;
    if (rd) begin
      case (bus_addr)
        3'd0: m_rd = s;
        3'd1: m_rd = (m_fifo.size() > 0) ? m_fifo[0] : 32'h0;
        3'd2: m_rd = m_mask;
        3'd3: m_rd = m_ec;
        3'd4: m_rd = status_of();
        default: m_rd = 32'h0;
      endcase
    end
    clr    = (wr && bus_addr == 3'd3) ? bus_wdata : 32'h0;
    ec_n   = (m_ec & ~clr) | ev;
    mask_n = (wr && bus_addr == 3'd2) ? bus_wdata : m_mask;
    push   = (ev & m_mask) != 0;
    pop    = rd && bus_addr == 3'd1 && m_fifo.size() > 0;
    drop   = 1'b0;
    if (pop) void'(m_fifo.pop_front());
    if (push) begin
      if (m_fifo.size() < D) m_fifo.push_back(s);
      else drop = 1'b1;
    end
    if (wr && bus_addr == 3'd4 && bus_wdata[2]) m_ovf = 1'b0;
    if (drop) m_ovf = 1'b1;
    m_ec   = ec_n;
    m_mask = mask_n;
    m_irq  = |(ec_n & mask_n);
    hist.push_back(in0);
    void'(hist.pop_front());
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("cyc_readdata", rd0, m_rd);
    chk("cyc_irq", {31'h0, irq0}, {31'h0, m_irq});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_idle();
    bus_cs = 1'b0; bus_rd = 1'b0; bus_wr = 1'b0; bus_sel = 1'b0;
  endtask

  task automatic rd_reg(input bit sel, input logic [2:0] addr, output logic [31:0] v);
    bus_cs = 1'b1; bus_sel = sel; bus_rd = 1'b1; bus_addr = addr;
    tick();
    v = sel ? rd1 : rd0;
    bus_idle();
  endtask

  task automatic wr_reg(input bit sel, input logic [2:0] addr, input logic [31:0] d);
    bus_cs = 1'b1; bus_sel = sel; bus_wr = 1'b1; bus_addr = addr; bus_wdata = d;
    tick();
    bus_idle();
  endtask

  // rising then falling toggle of bit0; the high word is queued as expected
  task automatic toggle_bit0();
    logic [31:0] w;
    w = ($urandom() & 32'hFFFF_FFFE) | 32'h1;
    in0 = w;
    exp_q.push_back(w);
    idle(3);
    in0 = $urandom() & 32'hFFFF_FFFE;
    idle(3);
  endtask

  initial begin
    logic [31:0] v, w;
    hist = '{32'h0, 32'h0, 32'h0};
    m_ec = '0; m_mask = '0; m_rd = '0; m_ovf = 1'b0; m_irq = 1'b0;
    @(negedge clk);

    // reset state
    idle(2);
    chk("reset_readdata", rd0, 32'h0);
    chk("reset_irq", {31'h0, irq0}, 32'h0);
    rst_n = 1'b1;
    idle(3);

    // falling-edge instance: 0 -> FF -> 0F captures only 0xF0
    in1 = 8'hFF; idle(5);
    rd_reg(1'b1, 3'd3, v);
    chk("fall_no_capture_on_rise", v, 32'h0);
    in1 = 8'h0F; idle(5);
    rd_reg(1'b1, 3'd3, v);
    chk("fall_capture", v, 32'hF0);

    // basic rising capture, irq and FIFO snapshot
    wr_reg(1'b0, 3'd2, 32'h1);
    in0 = 32'h5;
    idle(2);
    chk("irq_before_capture", {31'h0, irq0}, 32'h0);
    tick();
    chk("irq_after_capture", {31'h0, irq0}, 32'h1);
    rd_reg(1'b0, 3'd3, v);
    chk("edge_capture_5", v, 32'h5);
    rd_reg(1'b0, 3'd4, v);
    chk("status_count1", v, 32'h100);
    rd_reg(1'b0, 3'd1, v);
    chk("fifo_head_5", v, 32'h5);
    rd_reg(1'b0, 3'd4, v);
    chk("status_empty", v, 32'h1);

    // clear collides with a new rising edge on bit 2
    in0 = 32'h1; idle(4);
    in0 = 32'h5; idle(2);
    wr_reg(1'b0, 3'd3, 32'h5);
    rd_reg(1'b0, 3'd3, v);
    chk("set_beats_clear", v, 32'h4);
    wr_reg(1'b0, 3'd3, 32'hFFFF_FFFF);
    tick();
    chk("irq_cleared", {31'h0, irq0}, 32'h0);

    // overflow: 9 rising edges, 8 kept
    in0 = 32'h0; idle(4);
    wr_reg(1'b0, 3'd3, 32'hFFFF_FFFF);
    exp_q.delete();
    for (int i = 0; i < 9; i++) toggle_bit0();
    void'(exp_q.pop_back());
    rd_reg(1'b0, 3'd4, v);
    chk("status_full_ovf", v, 32'h806);
    for (int i = 0; i < 8; i++) begin
      rd_reg(1'b0, 3'd1, v);
      w = exp_q.pop_front();
      chk("drain_order", v, w);
    end
    rd_reg(1'b0, 3'd4, v);
    chk("status_empty_ovf", v, 32'h5);
    rd_reg(1'b0, 3'd1, v);
    chk("empty_read_zero", v, 32'h0);
    wr_reg(1'b0, 3'd4, 32'h4);
    rd_reg(1'b0, 3'd4, v);
    chk("ovf_cleared", v, 32'h1);

    // push and pop in the same cycle while full
    for (int i = 0; i < 8; i++) toggle_bit0();
    rd_reg(1'b0, 3'd4, v);
    chk("status_full", v, 32'h802);
    w = ($urandom() & 32'hFFFF_FFFE) | 32'h1;
    in0 = w;
    idle(2);
    rd_reg(1'b0, 3'd1, v);
    chk("pushpop_head", v, exp_q.pop_front());
    exp_q.push_back(w);
    rd_reg(1'b0, 3'd4, v);
    chk("pushpop_status", v, 32'h802);
    for (int i = 0; i < 8; i++) begin
      rd_reg(1'b0, 3'd1, v);
      chk("pushpop_drain", v, exp_q.pop_front());
    end

    // random bus traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) in0 = $urandom();
      case ($urandom_range(0, 3))
        0: begin
          bus_cs = 1'b1; bus_rd = 1'b1; bus_addr = 3'($urandom_range(0, 7));
        end
        1: begin
          bus_cs = 1'b1; bus_wr = 1'b1; bus_addr = 3'($urandom_range(0, 7));
          bus_wdata = $urandom();
        end
        default: bus_idle();
      endcase
      tick();
      bus_idle();
    end

    // reset mid-stream with entries queued and irq high
    wr_reg(1'b0, 3'd2, 32'h1);
    for (int i = 0; i < 2 * D && m_fifo.size() > 0; i++) rd_reg(1'b0, 3'd1, v);
    in0 = 32'h0; idle(4);
    wr_reg(1'b0, 3'd3, 32'hFFFF_FFFF);
    wr_reg(1'b0, 3'd4, 32'h4);
    exp_q.delete();
    for (int i = 0; i < 3; i++) toggle_bit0();
    chk("pre_reset_irq", {31'h0, irq0}, 32'h1);
    rd_reg(1'b0, 3'd4, v);
    chk("pre_reset_count3", v, 32'h300);
    rst_n = 1'b0;
    tick();
    chk("mid_reset_irq", {31'h0, irq0}, 32'h0);
    chk("mid_reset_readdata", rd0, 32'h0);
    rst_n = 1'b1;
    rd_reg(1'b0, 3'd4, v);
    chk("post_reset_status", v, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
